// File: rtl/branch_pred_ctrl_if.sv
// Prediction/update bundle between the fetch/execute pipeline and the branch predictor.
// The slave side is the predictor. The master side is the pipeline or testbench that drives it.
interface branch_pred_ctrl_if;
  logic [31:0] pc_IF;
  logic        stall_IF;
  logic        Flush_B;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        pre_br;
  logic [31:0] pre_pc;
  logic        pre_br_EX;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    output pc_IF, stall_IF, Flush_B, upd_valid, upd_pc, upd_taken, upd_target,
    input  pre_br, pre_pc, pre_br_EX, br_cnt, mispred_cnt
  );

  modport slave (
    input  pc_IF, stall_IF, Flush_B, upd_valid, upd_pc, upd_taken, upd_target,
    output pre_br, pre_pc, pre_br_EX, br_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// BHT (2-bit counters) + tagged BTB predictor. Lookup has 0-cycle latency, and training takes effect on the next edge.
// There is no backpressure: stall_IF holds the ID copy of the prediction and Flush_B clears both stages.
module branch_pred_ctrl #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic               cpu_clk,
  input logic               cpu_rst_n,
  branch_pred_ctrl_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         cnt_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             pre_br;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       cnt_nxt;

  logic        pre_br_id_q;
  logic        pre_br_ex_q;
  logic [31:0] br_cnt_q;
  logic [31:0] mispred_cnt_q;

  // Word-aligned PCs: the two low bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bp.pc_IF[1:0], bp.upd_pc[1:0]};

  assign lk_idx = bp.pc_IF[IDX_W+1:2];
  assign lk_tag = bp.pc_IF[31:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // Reset is ANDed in so that the IF stage sees a plain fall-through while reset is asserted.
  assign pre_br    = cpu_rst_n && lk_hit && cnt_q[lk_idx][1];
  assign bp.pre_br = pre_br;
  assign bp.pre_pc = pre_br ? tgt_q[lk_idx] : bp.pc_IF + 32'd4;

  assign up_idx = bp.upd_pc[IDX_W+1:2];
  assign up_tag = bp.upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    cnt_nxt = cnt_q[up_idx];
    if (!up_hit) begin
      cnt_nxt = bp.upd_taken ? 2'b10 : CNT_INIT;
    end else if (bp.upd_taken) begin
      if (cnt_q[up_idx] != 2'b11) cnt_nxt = cnt_q[up_idx] + 2'd1;
    end else begin
      if (cnt_q[up_idx] != 2'b00) cnt_nxt = cnt_q[up_idx] - 2'd1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (bp.upd_valid) begin
      valid_q[up_idx] <= 1'b1;
      cnt_q[up_idx]   <= cnt_nxt;
    end
  end

  // Tag and target storage is qualified by valid_q, so it is left without reset.
  always_ff @(posedge cpu_clk) begin
    if (bp.upd_valid) begin
      if (!up_hit) tag_q[up_idx] <= up_tag;
      if (!up_hit || bp.upd_taken) tgt_q[up_idx] <= bp.upd_target;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      pre_br_id_q <= 1'b0;
      pre_br_ex_q <= 1'b0;
    end else if (bp.Flush_B) begin
      pre_br_id_q <= 1'b0;
      pre_br_ex_q <= 1'b0;
    end else if (bp.stall_IF) begin
      pre_br_ex_q <= 1'b0;
    end else begin
      pre_br_id_q <= pre_br;
      pre_br_ex_q <= pre_br_id_q;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (bp.upd_valid) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (pre_br_ex_q != bp.upd_taken) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bp.pre_br_EX   = pre_br_ex_q;
  assign bp.br_cnt      = br_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;

endmodule
